apb_slave_mem: RTL

- APB3 completer (slave) with an internal register-file memory; the responder end of the existing APB master bridge.
- The master asserts psel for one slave and uses paddr[8] as the slave select; one instance per slave (two in the system).
- Programmable wait states and PSLVERR on out-of-range word addresses.
- Used as the DUT-side slave model and as synthesizable RTL.

---
 rtl/apb_slave_mem.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a resettable register-file memory.
// Wait states are programmable, and out-of-range word indices return PSLVERR without touching memory.
module apb_slave_mem #(
  parameter int unsigned AW          = 9,
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic          pready,
  output logic [DW-1:0] prdata,
  output logic          pslverr
);

  localparam int unsigned IW = AW - 1;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            setup;
  logic            in_err;
  logic            go_resp;
  logic            mem_we;

  // paddr[AW-1] selects between slaves at the system level and is not decoded here.
  logic            unused_slave_sel;
  assign unused_slave_sel = paddr[AW-1];

  assign setup  = psel && !penable;
  assign in_err = (32'(paddr[IW-1:0]) >= DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    go_resp   = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          idx_d   = paddr[IW-1:0];
          wr_d    = pwrite;
          wdata_d = pwdata;
          err_d   = in_err;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q == '0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = wr_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase

    // The response uses the _d view of the transfer so the zero-wait path
    // (entering RESP straight from setup) sees the address being latched.
    if (go_resp) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!wr_d && !err_d) begin
        prdata_d = mem_q[idx_d[MW-1:0]];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (mem_we) begin
        mem_q[idx_q[MW-1:0]] <= wdata_q;
      end
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule
